// File: rtl/prg_bus_arb.sv
// PRG memory port arbiter: M2-retimed CPU accesses (strict priority) share the port with a
// byte-wise background DMA requester. Define PRG_ARB_WPROT_EN to add CPU write protection (wprot/wp_hit).
module prg_bus_arb #(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned ACC_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_m2,
    input  logic              cpu_ce,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dati,
    output logic [7:0]        cpu_dato,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_dati,
    output logic              dma_ack,
    output logic [7:0]        dma_dato,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dato,
    input  logic [7:0]        mem_dati,
    output logic              mem_oe,
    output logic              mem_we,
    output logic              busy,
`ifdef PRG_ARB_WPROT_EN
    input  logic              wprot,
    output logic              wp_hit,
`endif
    output logic              err_ovr
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        DMA_ACC
    } state_t;

    localparam logic [3:0] LAST = 4'(ACC_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_m2_s1;
    logic              r_m2_s;
    logic              r_m2_d;
    logic              r_cpu_pend;
    logic              r_cpu_wr;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic [7:0]        r_cpu_dat;
    logic              r_wr;
    logic              r_wp_blk;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_dato;
    logic [7:0]        r_cpu_dato;
    logic [7:0]        r_dma_dato;
    logic              r_dma_ack;
    logic              r_err_ovr;
    logic              w_rise;
    logic              w_fall;
    logic              w_cpu_evt;
    logic              w_last;
    logic              w_start_cpu;
    logic              w_start_dma;
    logic              w_wprot;

`ifdef PRG_ARB_WPROT_EN
    logic r_wp_hit;
    assign w_wprot = wprot;
    assign wp_hit  = r_wp_hit;
`else
    assign w_wprot = 1'b0;
`endif

    // Reads are requested on M2 rise, writes on M2 fall (data valid late in the CPU cycle).
    assign w_rise    = r_m2_s & ~r_m2_d;
    assign w_fall    = ~r_m2_s & r_m2_d;
    assign w_cpu_evt = cpu_ce & ((w_rise & cpu_rw) | (w_fall & ~cpu_rw));
    assign w_last    = (r_state != IDLE) && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_cpu = 1'b0;
        w_start_dma = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_cpu_pend) begin
                    w_state_nxt = CPU_ACC;
                    w_start_cpu = 1'b1;
                end else if (dma_req) begin
                    w_state_nxt = DMA_ACC;
                    w_start_dma = 1'b1;
                end
            end
            CPU_ACC, DMA_ACC: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m2_s1    <= 1'b0;
            r_m2_s     <= 1'b0;
            r_m2_d     <= 1'b0;
            r_cpu_pend <= 1'b0;
            r_cpu_wr   <= 1'b0;
            r_cpu_addr <= '0;
            r_cpu_dat  <= '0;
            r_wr       <= 1'b0;
            r_wp_blk   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_dato <= '0;
            r_cpu_dato <= '1;
            r_dma_dato <= '0;
            r_dma_ack  <= 1'b0;
            r_err_ovr  <= 1'b0;
            r_cnt      <= '0;
`ifdef PRG_ARB_WPROT_EN
            r_wp_hit   <= 1'b0;
`endif
        end else begin
            r_m2_s1 <= cpu_m2;
            r_m2_s  <= r_m2_s1;
            r_m2_d  <= r_m2_s;

            // A fresh edge wins over the IDLE consume so a same-cycle request is never lost.
            if (w_cpu_evt) begin
                r_cpu_pend <= 1'b1;
                r_cpu_addr <= cpu_addr;
                r_cpu_wr   <= ~cpu_rw;
                if (!cpu_rw) begin
                    r_cpu_dat <= cpu_dati;
                end
                if (r_cpu_pend) begin
                    r_err_ovr <= 1'b1;
                end
            end else if (w_start_cpu) begin
                r_cpu_pend <= 1'b0;
            end

            if (w_start_cpu) begin
                r_mem_addr <= r_cpu_addr;
                r_mem_dato <= r_cpu_dat;
                r_wr       <= r_cpu_wr;
                r_wp_blk   <= r_cpu_wr & w_wprot;
            end else if (w_start_dma) begin
                r_mem_addr <= dma_addr;
                r_mem_dato <= dma_dati;
                r_wr       <= dma_we;
                r_wp_blk   <= 1'b0;
            end
`ifdef PRG_ARB_WPROT_EN
            if (w_start_cpu && r_cpu_wr && wprot) begin
                r_wp_hit <= 1'b1;
            end
`endif

            r_cnt     <= ((r_state == IDLE) || w_last) ? '0 : r_cnt + 4'd1;
            r_dma_ack <= w_last && (r_state == DMA_ACC);

            if (w_last && !r_wr) begin
                if (r_state == CPU_ACC) begin
                    r_cpu_dato <= mem_dati;
                end else begin
                    r_dma_dato <= mem_dati;
                end
            end
        end
    end

    // Write strobe skips first and last count to give address/data one cycle of setup and hold.
    assign mem_oe   = (r_state != IDLE) && !r_wr;
    assign mem_we   = (r_state != IDLE) && r_wr && !r_wp_blk && (r_cnt != 4'd0) && (r_cnt != LAST);
    assign busy     = (r_state != IDLE);
    assign mem_addr = r_mem_addr;
    assign mem_dato = r_mem_dato;
    assign cpu_dato = r_cpu_dato;
    assign dma_dato = r_dma_dato;
    assign dma_ack  = r_dma_ack;
    assign err_ovr  = r_err_ovr;

endmodule

// File: tb/tb_prg_bus_arb.sv
// Bench for prg_bus_arb: transaction-level reference model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized CPU/DMA traffic.
module tb_prg_bus_arb;
    localparam int unsigned AW  = 23;
    localparam int unsigned ACC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_m2 = 1'b0, cpu_ce = 1'b0, cpu_rw = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_dati = '0;
    logic [7:0]    cpu_dato;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [7:0]    dma_dati = '0;
    logic          dma_ack;
    logic [7:0]    dma_dato;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dato, mem_dati;
    logic          mem_oe, mem_we, busy, err_ovr;
`ifdef PRG_ARB_WPROT_EN
    logic          wprot = 1'b0;
    logic          wp_hit;
`endif

    prg_bus_arb #(.ADDR_W(AW), .ACC_CYC(ACC)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2), .cpu_ce(cpu_ce), .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr), .cpu_dati(cpu_dati), .cpu_dato(cpu_dato),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_dati(dma_dati),
        .dma_ack(dma_ack), .dma_dato(dma_dato), .mem_addr(mem_addr), .mem_dato(mem_dato),
        .mem_dati(mem_dati), .mem_oe(mem_oe), .mem_we(mem_we), .busy(busy),
`ifdef PRG_ARB_WPROT_EN
        .wprot(wprot), .wp_hit(wp_hit),
`endif
        .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Physical memory behind the port, and the model's own view of what it must contain.
    logic [7:0] phys [0:1023];
    logic [7:0] mm   [0:1023];
    assign mem_dati = phys[mem_addr[9:0]];
    initial forever begin
        @(posedge clk);
        if (mem_we) phys[mem_addr[9:0]] = mem_dato;
    end

    // Reference model: one pending CPU request record and one in-flight access record.
    bit            m_pend, m_pwr;
    logic [AW-1:0] m_paddr;
    logic [7:0]    m_pdat;
    bit            m_act, m_cpu, m_wr, m_prot;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_dat;
    int unsigned   m_age;
    logic [7:0]    m_cpu_dato, m_dma_dato;
    bit            m_ack, m_err, m_wph;
    bit            h1, h2, h3;

    task automatic model_reset();
        m_pend = 0; m_pwr = 0; m_paddr = '0; m_pdat = '0;
        m_act = 0; m_cpu = 0; m_wr = 0; m_prot = 0; m_addr = '0; m_dat = '0; m_age = 0;
        m_cpu_dato = 8'hFF; m_dma_dato = 8'h00; m_ack = 0; m_err = 0; m_wph = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic model_step();
        bit was_pend, rise, fall;
        was_pend = m_pend;
        m_ack = 0;
        if (m_act) begin
            if (m_age == ACC - 1) begin
                if (m_wr) begin
                    if (!m_prot) mm[m_addr[9:0]] = m_dat;
                end else if (m_cpu) begin
                    m_cpu_dato = mm[m_addr[9:0]];
                end else begin
                    m_dma_dato = mm[m_addr[9:0]];
                end
                if (!m_cpu) m_ack = 1;
                m_act = 0;
            end else begin
                m_age++;
            end
        end else if (m_pend) begin
            m_act = 1; m_cpu = 1; m_age = 0; m_wr = m_pwr; m_addr = m_paddr; m_dat = m_pdat;
            m_pend = 0; m_prot = 0;
`ifdef PRG_ARB_WPROT_EN
            m_prot = m_pwr && wprot;
            if (m_prot) m_wph = 1;
`endif
        end else if (dma_req) begin
            m_act = 1; m_cpu = 0; m_age = 0; m_wr = dma_we; m_addr = dma_addr; m_dat = dma_dati;
            m_prot = 0;
        end
        rise = h2 && !h3;
        fall = !h2 && h3;
        if (cpu_ce && ((rise && cpu_rw) || (fall && !cpu_rw))) begin
            if (was_pend) m_err = 1;
            m_pend = 1; m_pwr = !cpu_rw; m_paddr = cpu_addr;
            if (!cpu_rw) m_pdat = cpu_dati;
        end
        h3 = h2; h2 = h1; h1 = cpu_m2;
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("busy", busy, m_act);
            check("mem_oe", mem_oe, m_act && !m_wr);
            check("mem_we", mem_we, m_act && m_wr && !m_prot && m_age >= 1 && m_age <= ACC - 2);
            check("mem_addr", mem_addr, m_addr);
            if (m_act && m_wr) check("mem_dato", mem_dato, m_dat);
            check("cpu_dato", cpu_dato, m_cpu_dato);
            check("dma_ack", dma_ack, m_ack);
            check("dma_dato", dma_dato, m_dma_dato);
            check("err_ovr", err_ovr, m_err);
`ifdef PRG_ARB_WPROT_EN
            check("wp_hit", wp_hit, m_wph);
`endif
        end
    end

    // Event counters for the directed scenarios.
    logic [AW-1:0] tgt1 = '0, tgt2 = '0, first_addr = '0;
    int unsigned   n_t1, n_t2, n_oe, n_we, n_ack;
    bit            got_first;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mem_oe && mem_addr == tgt1) n_t1++;
            if (mem_oe && mem_addr == tgt2) n_t2++;
            if (mem_oe) n_oe++;
            if (mem_we) n_we++;
            if (dma_ack) n_ack++;
            if (busy && !got_first) begin
                got_first  = 1;
                first_addr = mem_addr;
            end
        end
    end

    task automatic clr();
        n_t1 = 0; n_t2 = 0; n_oe = 0; n_we = 0; n_ack = 0; got_first = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(input string nm);
        int unsigned k = 0;
        while (!dma_ack && k < 400) begin
            tick();
            k++;
        end
        check(nm, dma_ack, 1'b1);
    endtask

    task automatic wait_idle(input string nm);
        int unsigned k = 0, quiet = 0;
        while (quiet < 8 && k < 600) begin
            tick();
            k++;
            quiet = busy ? 0 : quiet + 1;
        end
        check(nm, quiet >= 8, 1'b1);
    endtask

    task automatic cpu_cycle(input logic rw, input logic [AW-1:0] a, input logic [7:0] d,
                             input int unsigned hi, input int unsigned lo);
        cpu_ce = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_dati = d;
        cpu_m2 = 1'b1;
        repeat (hi) tick();
        cpu_m2 = 1'b0;
        repeat (lo) tick();
        cpu_ce = 1'b0;
    endtask

    task automatic cpu_rand();
        for (int i = 0; i < 120; i++) begin
            cpu_ce   = ($urandom_range(0, 7) != 0);
            cpu_rw   = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom);
            cpu_dati = 8'($urandom);
`ifdef PRG_ARB_WPROT_EN
            wprot    = ($urandom_range(0, 3) == 0);
`endif
            cpu_m2 = 1'b1;
            repeat ($urandom_range(2, 7)) tick();
            cpu_m2 = 1'b0;
            repeat ($urandom_range(2, 7)) tick();
        end
        cpu_ce = 1'b0;
    endtask

    task automatic dma_rand();
        for (int i = 0; i < 120; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            dma_we   = 1'($urandom_range(0, 1));
            dma_addr = AW'($urandom);
            dma_dati = 8'($urandom);
            dma_req  = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                tick();
                dma_req = 1'b0;
            end else begin
                wait_ack("dma_rand_ack");
                if ($urandom_range(0, 1) == 1) dma_req = 1'b0;
                tick();
            end
        end
        dma_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            phys[i] = 8'($urandom);
            mm[i]   = phys[i];
        end
        clr();
        repeat (3) tick();
        check("rst_cpu_dato", cpu_dato, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_oe", mem_oe, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_dma_ack", dma_ack, 1'b0);
        check("rst_err_ovr", err_ovr, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dma_dato", dma_dato, 8'h00);
        rst_n = 1'b1;
        repeat (2) tick();

        // CPU read 0x04123 holding 0xA5.
        phys[10'h123] = 8'hA5; mm[10'h123] = 8'hA5;
        clr(); tgt1 = 23'h04123;
        cpu_cycle(1'b1, 23'h04123, 8'h00, 6, 10);
        wait_idle("t1_idle");
        check("t1_oe_cycles", n_t1, 4);
        check("t1_cpu_dato", cpu_dato, 8'hA5);
        check("t1_we_cycles", n_we, 0);

        // CPU write 0x00010 <= 0x3C.
        clr(); tgt1 = 23'h00010;
        cpu_cycle(1'b0, 23'h00010, 8'h3C, 6, 10);
        wait_idle("t2_idle");
        check("t2_we_cycles", n_we, 2);
        check("t2_oe_cycles", n_oe, 0);
        check("t2_mem", phys[10'h010], 8'h3C);

        // CPU pending and DMA request in the same IDLE cycle.
        clr();
        cpu_ce = 1'b1; cpu_rw = 1'b1; cpu_addr = 23'h00200;
        dma_we = 1'b0; dma_addr = 23'h00300;
        cpu_m2 = 1'b1;
        repeat (3) tick();
        dma_req = 1'b1;
        repeat (3) tick();
        cpu_m2 = 1'b0;
        wait_ack("t3_ack");
        dma_req = 1'b0;
        wait_idle("t3_idle");
        cpu_ce = 1'b0;
        check("t3_first_addr", first_addr, 23'h00200);
        check("t3_ack_count", n_ack, 1);

        // M2 rise while a DMA read sits at count 1.
        phys[10'h2AA] = 8'h5A; mm[10'h2AA] = 8'h5A;
        clr(); tgt1 = 23'h00155;
        dma_we = 1'b0; dma_addr = 23'h002AA; dma_req = 1'b1;
        repeat (2) tick();
        cpu_ce = 1'b1; cpu_rw = 1'b1; cpu_addr = 23'h00155; cpu_m2 = 1'b1;
        wait_ack("t4_ack");
        dma_req = 1'b0;
        check("t4_dma_dato", dma_dato, 8'h5A);
        repeat (2) tick();
        cpu_m2 = 1'b0;
        repeat (6) tick();
        cpu_ce = 1'b0;
        wait_idle("t4_idle");
        check("t4_cpu_oe_cycles", n_t1, 4);
        check("t4_ack_count", n_ack, 1);

        // Two M2 reads while the port is held by a DMA access.
        clr(); tgt1 = 23'h000A0; tgt2 = 23'h000B0;
        dma_we = 1'b0; dma_addr = 23'h000C0;
        cpu_ce = 1'b1; cpu_rw = 1'b1; cpu_addr = 23'h000A0;
        dma_req = 1'b1; cpu_m2 = 1'b1;
        tick(); cpu_m2 = 1'b0;
        tick(); cpu_m2 = 1'b1;
        tick(); cpu_addr = 23'h000B0;
        wait_ack("t5_ack");
        dma_req = 1'b0;
        repeat (3) tick();
        cpu_m2 = 1'b0;
        repeat (6) tick();
        cpu_ce = 1'b0;
        wait_idle("t5_idle");
        check("t5_err_ovr", err_ovr, 1'b1);
        check("t5_first_oe", n_t1, 0);
        check("t5_second_oe", n_t2, 4);

`ifdef PRG_ARB_WPROT_EN
        clr(); wprot = 1'b1;
        cpu_cycle(1'b0, 23'h00020, 8'h55, 6, 10);
        wait_idle("t6_idle");
        check("t6_we_cycles", n_we, 0);
        check("t6_wp_hit", wp_hit, 1'b1);
        wprot = 1'b0;
        clr();
        dma_we = 1'b1; dma_addr = 23'h00021; dma_dati = 8'h66; dma_req = 1'b1;
        wait_ack("t6_dma_ack");
        dma_req = 1'b0;
        wait_idle("t6_dma_idle");
        check("t6_dma_we_cycles", n_we, 2);
        check("t6_dma_mem", phys[10'h021], 8'h66);
`endif

        fork
            cpu_rand();
            dma_rand();
        join
        wait_idle("rand_idle");

        // Reset in the middle of a DMA write.
        dma_we = 1'b1; dma_addr = 23'h00333; dma_dati = 8'h77; dma_req = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        dma_req = 1'b0;
        tick();
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_we", mem_we, 1'b0);
        check("rst_mid_ack", dma_ack, 1'b0);
        check("rst_mid_err", err_ovr, 1'b0);
        rst_n = 1'b1;
        clr();
        repeat (8) tick();
        check("rst_mid_no_ack", n_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
